aes_inv_mix_columns: RTL



---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_inv_mix_column.sv | 55 +++++
 rtl/aes_inv_mix_columns.sv | 108 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: engine FSM states, GF(2^8) reduction constant,
// column/byte slicing helpers and the xtime primitive.
package aes_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned COL_W     = 32;
  localparam int unsigned NUM_COLS  = 4;
  localparam int unsigned STATE_W   = COL_W * NUM_COLS;
  localparam int unsigned COL_IDX_W = 2;

  // Byte lane MSBs inside a column; byte 0 sits in the top lane.
  localparam int unsigned B0_MSB = COL_W - 1;
  localparam int unsigned B1_MSB = COL_W - 1 - BYTE_W;
  localparam int unsigned B2_MSB = COL_W - 1 - 2 * BYTE_W;
  localparam int unsigned B3_MSB = COL_W - 1 - 3 * BYTE_W;

  localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by {02} modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [COL_W-1:0] get_col(input logic [STATE_W-1:0]   s,
                                               input logic [COL_IDX_W-1:0] c);
    logic [COL_W-1:0] r;
    r = '0;
    case (c)
      2'd0:    r = s[STATE_W-1 -: COL_W];
      2'd1:    r = s[STATE_W-1-COL_W -: COL_W];
      2'd2:    r = s[STATE_W-1-2*COL_W -: COL_W];
      default: r = s[STATE_W-1-3*COL_W -: COL_W];
    endcase
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] put_col(input logic [STATE_W-1:0]   s,
                                                 input logic [COL_IDX_W-1:0] c,
                                                 input logic [COL_W-1:0]     v);
    logic [STATE_W-1:0] r;
    r = s;
    case (c)
      2'd0:    r[STATE_W-1 -: COL_W]         = v;
      2'd1:    r[STATE_W-1-COL_W -: COL_W]   = v;
      2'd2:    r[STATE_W-1-2*COL_W -: COL_W] = v;
      default: r[STATE_W-1-3*COL_W -: COL_W] = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// Combinational single-column InvMixColumns built from xtime chains.
// With AES_IMC_FWD_EN defined, a fwd input selects forward MixColumns instead.
module aes_inv_mix_column
  import aes_pkg::*;
(
`ifdef AES_IMC_FWD_EN
  input  logic             fwd,
`endif
  input  logic [COL_W-1:0] column,
  output logic [COL_W-1:0] result_c
);

  logic [BYTE_W-1:0] a0, a1, a2, a3;
  logic [COL_W-1:0]  inv_col;

  assign a0 = column[B0_MSB -: BYTE_W];
  assign a1 = column[B1_MSB -: BYTE_W];
  assign a2 = column[B2_MSB -: BYTE_W];
  assign a3 = column[B3_MSB -: BYTE_W];

  // {0e}p ^ {0b}q ^ {0d}r ^ {09}s, each factor decomposed into x2/x4/x8 terms.
  function automatic logic [BYTE_W-1:0] inv_row(input logic [BYTE_W-1:0] p,
                                                input logic [BYTE_W-1:0] q,
                                                input logic [BYTE_W-1:0] r,
                                                input logic [BYTE_W-1:0] s);
    logic [BYTE_W-1:0] p2, p4, p8, q2, q4, q8, r2, r4, r8, s2, s4, s8;
    p2 = xtime(p); p4 = xtime(p2); p8 = xtime(p4);
    q2 = xtime(q); q4 = xtime(q2); q8 = xtime(q4);
    r2 = xtime(r); r4 = xtime(r2); r8 = xtime(r4);
    s2 = xtime(s); s4 = xtime(s2); s8 = xtime(s4);
    return (p8 ^ p4 ^ p2) ^ (q8 ^ q2 ^ q) ^ (r8 ^ r4 ^ r) ^ (s8 ^ s);
  endfunction

  assign inv_col = {inv_row(a0, a1, a2, a3), inv_row(a1, a2, a3, a0),
                    inv_row(a2, a3, a0, a1), inv_row(a3, a0, a1, a2)};

`ifdef AES_IMC_FWD_EN
  // {02}p ^ {03}q ^ r ^ s
  function automatic logic [BYTE_W-1:0] fwd_row(input logic [BYTE_W-1:0] p,
                                                input logic [BYTE_W-1:0] q,
                                                input logic [BYTE_W-1:0] r,
                                                input logic [BYTE_W-1:0] s);
    return xtime(p) ^ xtime(q) ^ q ^ r ^ s;
  endfunction

  logic [COL_W-1:0] fwd_col;

  assign fwd_col  = {fwd_row(a0, a1, a2, a3), fwd_row(a1, a2, a3, a0),
                     fwd_row(a2, a3, a0, a1), fwd_row(a3, a0, a1, a2)};
  assign result_c = fwd ? fwd_col : inv_col;
`else
  assign result_c = inv_col;
`endif

endmodule

// File: rtl/aes_inv_mix_columns.sv
// Iterative InvMixColumns engine: one column per clock between two
// valid/ready handshakes. AES_IMC_FWD_EN adds a per-block forward-mode select.
module aes_inv_mix_columns
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
`ifdef AES_IMC_FWD_EN
  ,
  input  logic               fwd
`endif
);

  state_e                 state_q, state_d;
  logic [COL_IDX_W-1:0]   col_q, col_d;
  logic [STATE_W-1:0]     data_q, data_d;
  logic                   alive_q;
  logic [COL_W-1:0]       col_cur, col_new;

`ifdef AES_IMC_FWD_EN
  logic fwd_q, fwd_d;
`endif

  assign col_cur  = get_col(data_q, col_q);
  assign out_data = data_q;

  aes_inv_mix_column u_col (
`ifdef AES_IMC_FWD_EN
    .fwd      (fwd_q),
`endif
    .column   (col_cur),
    .result_c (col_new)
  );

  // alive_q holds in_ready low through reset and the first cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      data_q  <= '0;
      alive_q <= 1'b0;
`ifdef AES_IMC_FWD_EN
      fwd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      data_q  <= data_d;
      alive_q <= 1'b1;
`ifdef AES_IMC_FWD_EN
      fwd_q   <= fwd_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef AES_IMC_FWD_EN
    fwd_d     = fwd_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = alive_q;
        if (in_valid && alive_q) begin
          data_d  = in_data;
          col_d   = '0;
          state_d = BUSY;
`ifdef AES_IMC_FWD_EN
          fwd_d   = fwd;
`endif
        end
      end
      BUSY: begin
        data_d = put_col(data_q, col_q, col_new);
        col_d  = col_q + 2'd1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_data;
            col_d   = '0;
            state_d = BUSY;
`ifdef AES_IMC_FWD_EN
            fwd_d   = fwd;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
